// File: rtl/cache_pkg.sv
// Shared cache data-path definitions: way geometry, default word width and
// the line-fill sequencing states.
package cache_pkg;

  localparam int NUM_WAYS = 4;
  localparam int WAY_W    = 2;
  // Default word width, shared with the read-side 4-way mux.
  localparam int DATA_W   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_t;

  // One-hot select for a way index.
  function automatic logic [NUM_WAYS-1:0] way_onehot(input logic [WAY_W-1:0] way);
    return NUM_WAYS'(1) << way;
  endfunction

endpackage

// File: rtl/way_we_decode.sv
// 2-to-4 one-hot way decoder with enable; all-zero when disabled.
module way_we_decode
  import cache_pkg::*;
(
  input  logic                en,
  input  logic [WAY_W-1:0]    way,
  output logic [NUM_WAYS-1:0] we
);

  // Decode the target way into a single write-enable bit.
  always_comb begin
    // NOTE: assigning a default before the condition keeps this block purely
    // combinational; without it a disabled path would infer a latch.
    we = '0;
    if (en) we = way_onehot(way);
  end

endmodule

// File: rtl/way_fill_demux4.sv
// Line-fill demux: steers WORDS incoming words into one of four way data
// ports, generating a one-hot write enable and word offset per word, and
// sequences the fill (start, count, done).
module way_fill_demux4
  import cache_pkg::*;
#(
  parameter  int w     = DATA_W,
  parameter  int WORDS = 4,
  localparam int OW    = $clog2(WORDS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [WAY_W-1:0]    way_sel,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [w-1:0] in_data,
  output logic signed [w-1:0] out_0,
  output logic signed [w-1:0] out_1,
  output logic signed [w-1:0] out_2,
  output logic signed [w-1:0] out_3,
  output logic [NUM_WAYS-1:0] we,
  output logic [OW-1:0]       word_off,
  output logic                busy,
  output logic                done
);

  fill_state_t         state, state_nx;
  logic [WAY_W-1:0]    way_q;
  logic [OW-1:0]       cnt;
  logic                xfer;
  logic                last;
  logic [NUM_WAYS-1:0] we_nx;
  logic signed [w-1:0] data_q [NUM_WAYS];

  assign xfer = in_valid & in_ready;
  assign last = (cnt == OW'(WORDS - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic: start only honoured in IDLE; DONE lasts one cycle.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start)       state_nx = FILL;
      FILL:    if (xfer & last) state_nx = DONE;
      DONE:                     state_nx = IDLE;
      default:                  state_nx = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the state.
  always_comb begin
    in_ready = (state == FILL);
    busy     = (state != IDLE);
    done     = (state == DONE);
  end

  // Target way latch and word counter; counter restarts on every accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      way_q <= '0;
      cnt   <= '0;
    end else if (state == IDLE && start) begin
      way_q <= way_sel;
      cnt   <= '0;
    end else if (xfer) begin
      cnt   <= cnt + OW'(1);
    end
  end

  way_we_decode u_we_decode (
    .en  (xfer),
    .way (way_q),
    .we  (we_nx)
  );

  // Registered write enable and word offset; offset holds between transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we       <= '0;
      word_off <= '0;
    end else begin
      we <= we_nx;
      if (xfer) word_off <= cnt;
    end
  end

  // Output data bank: only the selected way's register loads, others hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this is a small flop bank whose outputs are visible ports, so it
      // is reset; a real RAM array would not be.
      for (int k = 0; k < NUM_WAYS; k++) data_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_WAYS; k++)
        if (we_nx[k]) data_q[k] <= in_data;
    end
  end

  assign out_0 = data_q[0];
  assign out_1 = data_q[1];
  assign out_2 = data_q[2];
  assign out_3 = data_q[3];

endmodule

// File: tb/tb_way_fill_demux4.sv
// Bench for way_fill_demux4: one 8-bit and one 16-bit instance driven with
// the same controls (8-bit instance sees the low byte of the data), compared
// every cycle against a transaction-level line-fill model.
module tb_way_fill_demux4;
  import cache_pkg::*;

  localparam int WORDS = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  way_sel = '0;
  logic        in_valid = 1'b0;
  logic [15:0] din = '0;

  logic              rdy8, busy8, done8;
  logic [3:0]        we8;
  logic [1:0]        off8;
  logic signed [7:0] o8 [4];
  logic              rdy16, busy16, done16;
  logic [3:0]        we16;
  logic [1:0]        off16;
  logic signed [15:0] o16 [4];

  int total = 0;
  int bad = 0;
  string phase = "init";

  always #5 clk = ~clk;

  way_fill_demux4 #(.w(8), .WORDS(WORDS)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .way_sel(way_sel),
    .in_valid(in_valid), .in_ready(rdy8), .in_data(din[7:0]),
    .out_0(o8[0]), .out_1(o8[1]), .out_2(o8[2]), .out_3(o8[3]),
    .we(we8), .word_off(off8), .busy(busy8), .done(done8)
  );

  way_fill_demux4 #(.w(16), .WORDS(WORDS)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .way_sel(way_sel),
    .in_valid(in_valid), .in_ready(rdy16), .in_data(din),
    .out_0(o16[0]), .out_1(o16[1]), .out_2(o16[2]), .out_3(o16[3]),
    .we(we16), .word_off(off16), .busy(busy16), .done(done16)
  );

  // Reference model: which way is being filled, how many words have landed,
  // what every way port last received, and the per-cycle pulses.
  logic [15:0] m_out [4];
  logic [3:0]  m_we;
  logic [1:0]  m_off;
  bit          m_fill, m_done;
  int          m_way, m_cnt;

  task automatic model_reset();
    for (int k = 0; k < 4; k++) m_out[k] = '0;
    m_we = '0; m_off = '0; m_fill = 0; m_done = 0; m_way = 0; m_cnt = 0;
  endtask

  // One clock edge of line-fill behaviour using the inputs held before it.
  task automatic model_edge();
    m_we = '0;
    if (m_done) begin
      m_done = 0;
    end else if (m_fill) begin
      if (in_valid) begin
        m_out[m_way] = din;
        m_we  = 4'b0001 << m_way;
        m_off = 2'(m_cnt);
        m_cnt++;
        if (m_cnt == WORDS) begin
          m_fill = 0;
          m_done = 1;
        end
      end
    end else if (start) begin
      m_fill = 1;
      m_way  = int'(way_sel);
      m_cnt  = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk({phase, ".we8"},    {12'h0, we8},   {12'h0, m_we});
    chk({phase, ".we16"},   {12'h0, we16},  {12'h0, m_we});
    chk({phase, ".off8"},   {14'h0, off8},  {14'h0, m_off});
    chk({phase, ".off16"},  {14'h0, off16}, {14'h0, m_off});
    chk({phase, ".done8"},  {15'h0, done8},  {15'h0, m_done});
    chk({phase, ".done16"}, {15'h0, done16}, {15'h0, m_done});
    chk({phase, ".busy8"},  {15'h0, busy8},  {15'h0, (m_fill | m_done)});
    chk({phase, ".busy16"}, {15'h0, busy16}, {15'h0, (m_fill | m_done)});
    chk({phase, ".rdy8"},   {15'h0, rdy8},   {15'h0, m_fill});
    chk({phase, ".rdy16"},  {15'h0, rdy16},  {15'h0, m_fill});
    chk({phase, ".onehot8"},  {15'h0, $onehot0(we8)},  16'h1);
    chk({phase, ".onehot16"}, {15'h0, $onehot0(we16)}, 16'h1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s.out8_%0d", phase, k),  {8'h0, o8[k]}, {8'h0, m_out[k][7:0]});
      chk($sformatf("%s.out16_%0d", phase, k), o16[k],        m_out[k]);
    end
  endtask

  task automatic drive(input bit s, input logic [1:0] ws, input bit v, input logic [15:0] d);
    start = s; way_sel = ws; in_valid = v; din = d;
  endtask

  // Advance one clock, update the model, then compare away from the edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    else       model_reset();
    #1;
    check_all();
  endtask

  // Start a fill of `way`, then feed random words with random gaps until the
  // model reports the last word landed. With `noisy`, start is held and
  // way_sel scrambled throughout. Returns with the DONE cycle current.
  task automatic run_fill(input logic [1:0] way, input bit noisy);
    int guard;
    drive(1'b1, way, 1'b0, 16'($urandom));
    tick();
    guard = 0;
    while (m_fill && guard < 64) begin
      drive(noisy, noisy ? 2'($urandom) : way, ($urandom_range(0, 3) != 0), 16'($urandom));
      tick();
      guard++;
    end
    total++;
    if (guard >= 64) begin
      bad++;
      $display("FAIL %s.fill_bound observed=%0d cycles expected<64", phase, guard);
    end
  endtask

  logic [15:0] basic_data [4];
  logic [15:0] gap_data [4];
  bit          gap_valid [7];

  initial begin
    int gi;
    model_reset();
    basic_data = '{16'hFF80, 16'hFFFF, 16'h0000, 16'h007F};
    gap_data   = '{16'h8000, 16'h3039, 16'hFFFE, 16'h7FFF};
    gap_valid  = '{1, 0, 0, 1, 1, 0, 1};

    // Reset held with random traffic on the inputs.
    phase = "reset_hold";
    for (int i = 0; i < 3; i++) begin
      drive(1'($urandom), 2'($urandom), 1'($urandom), 16'($urandom));
      tick();
    end
    @(negedge clk);
    rst_n = 1'b1;
    phase = "post_reset_idle";
    drive(1'b0, 2'd0, 1'b0, 16'h0);
    for (int i = 0; i < 3; i++) tick();

    // Basic fill of way 2 with extreme signed values.
    phase = "basic";
    drive(1'b1, 2'd2, 1'b0, 16'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 2'd2, 1'b1, basic_data[i]);
      tick();
    end
    drive(1'b0, 2'd0, 1'b0, 16'h0);
    tick();
    tick();

    // Gapped input to way 1.
    phase = "gapped";
    drive(1'b1, 2'd1, 1'b0, 16'h0);
    tick();
    gi = 0;
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 2'd1, gap_valid[i], gap_valid[i] ? gap_data[gi] : 16'($urandom));
      if (gap_valid[i]) gi++;
      tick();
    end
    drive(1'b0, 2'd0, 1'b0, 16'h0);
    tick();
    tick();

    // Start and way_sel churn during a fill of way 0 must be ignored.
    phase = "ignored_ctrl";
    run_fill(2'd0, 1'b1);
    phase = "start_in_done";
    drive(1'b1, 2'd3, 1'b0, 16'h0);
    tick();
    phase = "start_after_done";
    drive(1'b1, 2'd1, 1'b0, 16'h0);
    tick();
    phase = "refill_way1";
    while (m_fill) begin
      drive(1'b0, 2'($urandom), 1'b1, 16'($urandom));
      tick();
    end
    drive(1'b0, 2'd0, 1'b0, 16'h0);
    tick();
    tick();

    // Asynchronous reset part-way through a fill of way 3.
    phase = "midfill";
    drive(1'b1, 2'd3, 1'b0, 16'h0);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 2'd3, 1'b1, 16'($urandom) | 16'h0101);
      tick();
    end
    drive(1'b0, 2'd3, 1'b1, 16'h5A5A);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    phase = "async_reset";
    check_all();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    phase = "refill_way3";
    drive(1'b0, 2'd0, 1'b0, 16'h0);
    tick();
    run_fill(2'd3, 1'b0);
    drive(1'b0, 2'd0, 1'b0, 16'h0);
    tick();

    // One fill per way with random data and gaps.
    for (int wy = 0; wy < 4; wy++) begin
      phase = $sformatf("all_ways_%0d", wy);
      run_fill(2'(wy), 1'b0);
      drive(1'b0, 2'd0, 1'b0, 16'h0);
      tick();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
